// File: rtl/invsqrt_pkg.sv
// Shared constants for the InvSqrt pipeline: FSM encodings, shift-direction
// encoding common to shifter and normalizer, and datapath widths.
package invsqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int IN_W   = 32;
  localparam int MANT_W = 24;

endpackage

// File: rtl/normalizer.sv
// Iterative normalizer: shifts one bit per cycle until the leading one sits at MANT_W-1.
// Optional NORM_STICKY_EN adds a sticky output collecting bits lost on right shifts.
module normalizer #(
  parameter int IN_W   = invsqrt_pkg::IN_W,
  parameter int MANT_W = invsqrt_pkg::MANT_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   in,
  output logic [MANT_W-1:0] mant,
  output logic [CNT_W-1:0]  shift,
  output logic              direction,
  output logic              zero,
  output logic              busy,
  output logic              ready
`ifdef NORM_STICKY_EN
  ,
  output logic              sticky
`endif
);

  import invsqrt_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [IN_W-1:0]   work_reg, work_n;
  logic [CNT_W-1:0]  shift_n;
  logic              dir_n;
  logic              zero_n;
  logic              ready_n;
`ifdef NORM_STICKY_EN
  logic              sticky_n;
`endif

  assign mant = work_reg[MANT_W-1:0];
  assign busy = (state == ST_SHIFT);

  // Right shifts take priority so an oversized value is never pushed further left.
  always_comb begin
    state_n = state;
    work_n  = work_reg;
    shift_n = shift;
    dir_n   = direction;
    zero_n  = zero;
    ready_n = ready;
`ifdef NORM_STICKY_EN
    sticky_n = sticky;
`endif
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shift_n = '0;
          dir_n   = DIR_RIGHT;
`ifdef NORM_STICKY_EN
          sticky_n = 1'b0;
`endif
          if (in == '0) begin
            work_n  = '0;
            zero_n  = 1'b1;
            ready_n = 1'b1;
            state_n = ST_DONE;
          end else begin
            work_n  = in;
            zero_n  = 1'b0;
            ready_n = 1'b0;
            state_n = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (|work_reg[IN_W-1:MANT_W]) begin
          work_n  = work_reg >> 1;
          shift_n = shift + CNT_ONE;
          dir_n   = DIR_RIGHT;
`ifdef NORM_STICKY_EN
          sticky_n = sticky | work_reg[0];
`endif
        end else if (!work_reg[MANT_W-1]) begin
          work_n  = work_reg << 1;
          shift_n = shift + CNT_ONE;
          dir_n   = DIR_LEFT;
        end else begin
          ready_n = 1'b1;
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      work_reg  <= '0;
      shift     <= '0;
      direction <= 1'b0;
      zero      <= 1'b0;
      ready     <= 1'b0;
`ifdef NORM_STICKY_EN
      sticky    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      work_reg  <= work_n;
      shift     <= shift_n;
      direction <= dir_n;
      zero      <= zero_n;
      ready     <= ready_n;
`ifdef NORM_STICKY_EN
      sticky    <= sticky_n;
`endif
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: a leading-one reference model predicts each result,
// a monitor pops and compares whenever a new result appears on ready.
module tb_normalizer;
  import invsqrt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_val;
  logic [23:0] mant;
  logic [7:0]  shift;
  logic        direction, zero, busy, ready;
`ifdef NORM_STICKY_EN
  logic        sticky;
`endif

  normalizer dut (
    .clk(clk), .rst(rst), .start(start), .in(in_val),
    .mant(mant), .shift(shift), .direction(direction),
    .zero(zero), .busy(busy), .ready(ready)
`ifdef NORM_STICKY_EN
    , .sticky(sticky)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] orig;
    logic [23:0] mant;
    logic [7:0]  shift;
    logic        dir;
    logic        zero;
    logic        sticky;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  // Reference: locate the leading one and shift it to bit 23 in one step.
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    int p;
    int n;
    logic [31:0] s;
    e.orig = v; e.sticky = 1'b0; e.zero = 1'b0; p = -1;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    if (p < 0) begin
      e.mant = '0; e.shift = '0; e.dir = 1'b0; e.zero = 1'b1; e.lat = 0;
    end else if (p >= 23) begin
      n = p - 23;
      s = v >> n;
      e.mant = s[23:0]; e.shift = 8'(n); e.dir = 1'b0; e.lat = n + 1;
      for (int i = 0; i < n; i++) if (v[i]) e.sticky = 1'b1;
    end else begin
      n = 23 - p;
      s = v << n;
      e.mant = s[23:0]; e.shift = 8'(n); e.dir = 1'b1; e.lat = n + 1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Launch tracking: edges since the last accepted start, and whether the latest edge launched.
  logic launched = 1'b0;
  int   edges = 0;
  always @(posedge clk) begin
    if (rst) begin
      launched <= 1'b0;
      edges    <= 0;
    end else if (start && !busy) begin
      launched <= 1'b1;
      edges    <= 0;
    end else begin
      launched <= 1'b0;
      edges    <= edges + 1;
    end
  end

  logic ready_prev = 1'b0;
  logic [31:0] rt;
  logic [31:0] keep_mask;
  exp_t e;
  always @(negedge clk) begin
    if (!rst && ready && (!ready_prev || launched)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_result: got mant %h expected no result", mant);
      end else begin
        e = exp_q.pop_front();
        check("mant", 32'(mant), 32'(e.mant));
        check("shift", 32'(shift), 32'(e.shift));
        check("direction", 32'(direction), 32'(e.dir));
        check("zero", 32'(zero), 32'(e.zero));
        check("latency", 32'(edges), 32'(e.lat));
`ifdef NORM_STICKY_EN
        check("sticky", 32'(sticky), 32'(e.sticky));
`endif
        if (!e.zero) begin
          if (direction == DIR_RIGHT) rt = {8'h00, mant} << shift;
          else                        rt = {8'h00, mant} >> shift;
          keep_mask = ~((32'h1 << e.shift) - 32'h1);
          if (e.dir) check("round_trip", rt, e.orig);
          else       check("round_trip", rt, e.orig & keep_mask);
        end
      end
    end
    ready_prev <= rst ? 1'b0 : ready;
  end

  task automatic applyStimulus(input logic [31:0] v);
    @(negedge clk);
    in_val = v;
    start  = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitDone();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; start = 1'b0; in_val = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_shift", 32'(shift), 32'h0);
    check("rst_mant", 32'(mant), 32'h0);
    check("rst_zero", 32'(zero), 32'h0);
    check("rst_dir", 32'(direction), 32'h0);
    rst = 1'b0;

    applyStimulus(32'h0080_0000); waitDone();
    applyStimulus(32'h0000_0001); waitDone();
    applyStimulus(32'h8000_0001); waitDone();
    applyStimulus(32'h8000_0000); waitDone();
    applyStimulus(32'h0000_0000); waitDone();
    applyStimulus(32'h0000_0100); waitDone();
    applyStimulus(32'h0000_0000); waitDone();
    applyStimulus(32'h0000_0000); waitDone();
    applyStimulus(32'hFFFF_FFFF); waitDone();

    // A start pulse mid-operation must not disturb the running result.
    applyStimulus(32'h0000_0001);
    repeat (3) @(negedge clk);
    in_val = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_pulse", 32'(busy), 32'h1);
    waitDone();

    // Reset mid-operation aborts without leaving a partial result.
    @(negedge clk);
    in_val = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_shift", 32'(shift), 32'h0);
    check("abort_mant", 32'(mant), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      v = v >> $urandom_range(0, 32);
      applyStimulus(v);
      waitDone();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
